// File: rtl/axi_tgen_pkg.sv
// Shared encodings and AXI constants for the burst traffic generator.
package axi_tgen_pkg;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [3:0] CACHE_MOD   = 4'b0011;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Counter widths cover 256-beat bursts times 65535 bursts per frame.
    localparam int BEAT_IDX_W  = 24;
    localparam int BEAT_W      = 8;
    localparam int BURST_CNT_W = 16;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_tgen_if.sv
// AXI4 master-side bundle between the traffic generator and its slave.
interface axi_burst_tgen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  s_axi_awvalid, s_axi_awready;
    logic [ADDR_W-1:0]     s_axi_awaddr;
    logic [7:0]            s_axi_awlen;
    logic [2:0]            s_axi_awsize;
    logic [1:0]            s_axi_awburst;
    logic [3:0]            s_axi_awcache;
    logic                  s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [DATA_W-1:0]     s_axi_wdata;
    logic [DATA_W/8-1:0]   s_axi_wstrb;
    logic                  s_axi_bvalid, s_axi_bready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_arvalid, s_axi_arready;
    logic [ADDR_W-1:0]     s_axi_araddr;
    logic [7:0]            s_axi_arlen;
    logic [2:0]            s_axi_arsize;
    logic [1:0]            s_axi_arburst;
    logic [3:0]            s_axi_arcache;
    logic                  s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [DATA_W-1:0]     s_axi_rdata;
    logic [1:0]            s_axi_rresp;

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awcache,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready,
        output s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arcache,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rresp
    );

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awcache,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready,
        input  s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arcache,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rresp
    );

endinterface

// File: rtl/axi_tgen_addr_gen.sv
// Per-channel burst address, frame-global beat index and burst/beat position tracking.
module axi_tgen_addr_gen
    import axi_tgen_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              BURST_LEN  = 16,
    parameter int              NUM_BURSTS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              clear,
    input  logic              beat_adv,
    input  logic              burst_adv,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] beat_data,
    output logic              last_beat,
    output logic              last_burst
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * (DATA_W / 8));

    logic [BEAT_IDX_W-1:0]  beat_idx;
    logic [BEAT_W-1:0]      beat_in_burst;
    logic [BURST_CNT_W-1:0] burst_cnt;

    // Beat and burst advances may coincide on the read side; clear wins over both.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            addr          <= BASE_ADDR;
            beat_idx      <= '0;
            beat_in_burst <= '0;
            burst_cnt     <= '0;
        end else if (clear) begin
            addr          <= BASE_ADDR;
            beat_idx      <= '0;
            beat_in_burst <= '0;
            burst_cnt     <= '0;
        end else begin
            if (beat_adv) begin
                beat_idx      <= beat_idx + 1'b1;
                beat_in_burst <= last_beat ? '0 : beat_in_burst + 1'b1;
            end
            if (burst_adv) begin
                addr      <= addr + STEP;
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    assign last_beat  = (beat_in_burst == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (burst_cnt == BURST_CNT_W'(NUM_BURSTS - 1));
    assign beat_data  = DATA_W'(beat_idx);

endmodule

// File: rtl/axi_burst_tgen.sv
// AXI4 burst traffic generator: writes an incrementing pattern, reads it back and counts errors.
module axi_burst_tgen
    import axi_tgen_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              BURST_LEN  = 16,
    parameter int              NUM_BURSTS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        start_write,
    input  logic        start_read,
    output logic        wr_busy,
    output logic        rd_busy,
    output logic        wr_done,
    output logic        rd_done,
    output logic [15:0] err_cnt,
    axi_burst_tgen_if.master axi
);

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic awvalid, wvalid, bready, arvalid, rready;
    logic [ADDR_W-1:0] w_addr, r_addr;
    logic [DATA_W-1:0] w_data, r_data_exp;
    logic w_last_beat, w_last_burst, r_last_beat, r_last_burst;

    logic w_beat_adv, w_resp_hs, w_burst_adv, w_clear, wr_err;
    logic r_beat_hs, r_end, r_burst_adv, r_clear, rd_err, err_clear;
    logic [16:0] err_sum;

    assign w_beat_adv  = (wr_state == W_DATA) && axi.s_axi_wready;
    assign w_resp_hs   = (wr_state == W_RESP) && axi.s_axi_bvalid;
    assign w_burst_adv = w_resp_hs && !w_last_burst;
    assign w_clear     = w_resp_hs && w_last_burst;
    assign wr_err      = w_resp_hs && (axi.s_axi_bresp != RESP_OKAY);

    assign r_beat_hs   = (rd_state == R_DATA) && axi.s_axi_rvalid;
    assign r_end       = r_beat_hs && r_last_beat;
    assign r_burst_adv = r_end && !r_last_burst;
    assign r_clear     = r_end && r_last_burst;
    assign err_clear   = (rd_state == R_IDLE) && start_read;
    // Burst end is taken from our own beat count; rlast is only checked, never trusted.
    assign rd_err      = r_beat_hs && ((axi.s_axi_rdata != r_data_exp) ||
                                       (axi.s_axi_rresp != RESP_OKAY) ||
                                       (axi.s_axi_rlast != r_last_beat));

    axi_tgen_addr_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .NUM_BURSTS(NUM_BURSTS), .BASE_ADDR(BASE_ADDR)
    ) u_wr_gen (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .clear(w_clear),
        .beat_adv(w_beat_adv), .burst_adv(w_burst_adv), .addr(w_addr),
        .beat_data(w_data), .last_beat(w_last_beat), .last_burst(w_last_burst)
    );

    axi_tgen_addr_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .NUM_BURSTS(NUM_BURSTS), .BASE_ADDR(BASE_ADDR)
    ) u_rd_gen (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .clear(r_clear),
        .beat_adv(r_beat_hs), .burst_adv(r_burst_adv), .addr(r_addr),
        .beat_data(r_data_exp), .last_beat(r_last_beat), .last_burst(r_last_burst)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_state <= W_IDLE;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            wr_busy  <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (wr_state)
                W_IDLE: if (start_write) begin
                    wr_state <= W_ADDR;
                    awvalid  <= 1'b1;
                    wr_busy  <= 1'b1;
                end
                W_ADDR: if (axi.s_axi_awready) begin
                    wr_state <= W_DATA;
                    awvalid  <= 1'b0;
                    wvalid   <= 1'b1;
                end
                W_DATA: if (axi.s_axi_wready && w_last_beat) begin
                    wr_state <= W_RESP;
                    wvalid   <= 1'b0;
                    bready   <= 1'b1;
                end
                W_RESP: if (axi.s_axi_bvalid) begin
                    bready <= 1'b0;
                    if (w_last_burst) begin
                        wr_state <= W_IDLE;
                        wr_done  <= 1'b1;
                        wr_busy  <= 1'b0;
                    end else begin
                        wr_state <= W_ADDR;
                        awvalid  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_state <= R_IDLE;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            rd_busy  <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (rd_state)
                R_IDLE: if (start_read) begin
                    rd_state <= R_ADDR;
                    arvalid  <= 1'b1;
                    rd_busy  <= 1'b1;
                end
                R_ADDR: if (axi.s_axi_arready) begin
                    rd_state <= R_DATA;
                    arvalid  <= 1'b0;
                    rready   <= 1'b1;
                end
                R_DATA: if (r_end) begin
                    rready <= 1'b0;
                    if (r_last_burst) begin
                        rd_state <= R_IDLE;
                        rd_done  <= 1'b1;
                        rd_busy  <= 1'b0;
                    end else begin
                        rd_state <= R_ADDR;
                        arvalid  <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // A write error in the same cycle as a read-start clear still counts.
    assign err_sum = {1'b0, (err_clear ? 16'h0 : err_cnt)} + 17'(wr_err) + 17'(rd_err);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) err_cnt <= '0;
        else              err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign axi.s_axi_awvalid = awvalid;
    assign axi.s_axi_awaddr  = w_addr;
    assign axi.s_axi_awlen   = 8'(BURST_LEN - 1);
    assign axi.s_axi_awsize  = axi_size(DATA_W);
    assign axi.s_axi_awburst = BURST_INCR;
    assign axi.s_axi_awcache = CACHE_MOD;
    assign axi.s_axi_wvalid  = wvalid;
    assign axi.s_axi_wdata   = w_data;
    assign axi.s_axi_wstrb   = {(DATA_W/8){wvalid}};
    assign axi.s_axi_wlast   = wvalid && w_last_beat;
    assign axi.s_axi_bready  = bready;
    assign axi.s_axi_arvalid = arvalid;
    assign axi.s_axi_araddr  = r_addr;
    assign axi.s_axi_arlen   = 8'(BURST_LEN - 1);
    assign axi.s_axi_arsize  = axi_size(DATA_W);
    assign axi.s_axi_arburst = BURST_INCR;
    assign axi.s_axi_arcache = CACHE_MOD;
    assign axi.s_axi_rready  = rready;

endmodule

// File: tb/tb_axi_burst_tgen.sv
// Directed bench: small-burst DUT against a memory slave, plus a wide 256-beat instance.
module tb_axi_burst_tgen;
    localparam int BL = 4;
    localparam int NB = 2;

    logic axi_aclk = 1'b1;
    logic axi_aresetn = 1'b0;
    logic start_write = 1'b0, start_read = 1'b0;
    logic start_write2 = 1'b0, start_read2 = 1'b0;
    logic wr_busy, rd_busy, wr_done, rd_done;
    logic wr_busy2, rd_busy2, wr_done2, rd_done2;
    logic [15:0] err_cnt, err_cnt2;

    axi_burst_tgen_if #(.ADDR_W(32), .DATA_W(32)) axi ();
    axi_burst_tgen_if #(.ADDR_W(32), .DATA_W(64)) axi2 ();

    axi_burst_tgen #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(32'h0)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .start_write(start_write), .start_read(start_read),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_done(wr_done), .rd_done(rd_done), .err_cnt(err_cnt), .axi(axi));

    axi_burst_tgen #(.ADDR_W(32), .DATA_W(64), .BURST_LEN(256), .NUM_BURSTS(2), .BASE_ADDR(32'h0)) dut2 (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .start_write(start_write2), .start_read(start_read2),
        .wr_busy(wr_busy2), .rd_busy(rd_busy2), .wr_done(wr_done2), .rd_done(rd_done2), .err_cnt(err_cnt2), .axi(axi2));

    always #5 axi_aclk = ~axi_aclk;

    int n_cmp = 0, n_bad = 0;

    // slave controls (written by tasks only)
    bit bp = 0;
    int slverr_burst = -1, prem_rlast = -1, corrupt_idx = -1, clr_seq = 0;

    // slave / monitor state (written by the monitor only)
    int clr_seen = 0, w_idx = 0, r_idx = 0, b_pending = 0, b_count = 0, r_left = 0;
    int wr_done_cnt = 0, rd_done_cnt = 0, stab_viol = 0, strb_viol = 0;
    logic [31:0] mem [8];
    logic [31:0] aw_log[$], ar_log[$], wd_log[$];
    logic        wl_log[$];
    bit prev_aw_st = 0, prev_w_st = 0, prev_ar_st = 0;
    logic [31:0] prev_awaddr, prev_araddr, prev_wdata;
    logic prev_wlast;

    int wr_done2_cnt = 0, wlast2_cnt = 0;
    logic [31:0] aw2_log[$];
    logic [63:0] last_wd2 = '0;

    always @(posedge axi_aclk) begin
        if (clr_seq != clr_seen) begin
            clr_seen = clr_seq;
            aw_log.delete(); ar_log.delete(); wd_log.delete(); wl_log.delete();
            w_idx = 0; r_idx = 0; b_pending = 0; b_count = 0; r_left = 0;
        end
        if (axi.s_axi_awvalid && axi.s_axi_awready) aw_log.push_back(axi.s_axi_awaddr);
        if (axi.s_axi_wvalid && axi.s_axi_wready) begin
            wd_log.push_back(axi.s_axi_wdata);
            wl_log.push_back(axi.s_axi_wlast);
            mem[w_idx % 8] = axi.s_axi_wdata;
            w_idx++;
            if (axi.s_axi_wlast) b_pending++;
        end
        if (axi.s_axi_bvalid && axi.s_axi_bready) begin b_pending--; b_count++; end
        if (axi.s_axi_arvalid && axi.s_axi_arready) begin ar_log.push_back(axi.s_axi_araddr); r_left += BL; end
        if (axi.s_axi_rvalid && axi.s_axi_rready) begin r_left--; r_idx++; end
        if (wr_done) wr_done_cnt++;
        if (rd_done) rd_done_cnt++;
        if ((axi.s_axi_wvalid && axi.s_axi_wstrb != 4'hF) || (!axi.s_axi_wvalid && axi.s_axi_wstrb != 4'h0))
            strb_viol++;
        if (axi_aresetn) begin
            if (prev_aw_st && (!axi.s_axi_awvalid || axi.s_axi_awaddr != prev_awaddr)) stab_viol++;
            if (prev_ar_st && (!axi.s_axi_arvalid || axi.s_axi_araddr != prev_araddr)) stab_viol++;
            if (prev_w_st && (!axi.s_axi_wvalid || axi.s_axi_wdata != prev_wdata ||
                              axi.s_axi_wlast != prev_wlast)) stab_viol++;
            prev_aw_st = axi.s_axi_awvalid && !axi.s_axi_awready;
            prev_ar_st = axi.s_axi_arvalid && !axi.s_axi_arready;
            prev_w_st  = axi.s_axi_wvalid && !axi.s_axi_wready;
        end else begin
            prev_aw_st = 0; prev_ar_st = 0; prev_w_st = 0;
        end
        prev_awaddr = axi.s_axi_awaddr; prev_araddr = axi.s_axi_araddr;
        prev_wdata = axi.s_axi_wdata; prev_wlast = axi.s_axi_wlast;
    end

    always @(negedge axi_aclk) begin
        axi.s_axi_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.s_axi_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.s_axi_arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.s_axi_bvalid  = (b_pending > 0) && (axi.s_axi_bvalid === 1'b1 || !bp || $urandom_range(0, 1) == 1);
        axi.s_axi_bresp   = (b_count == slverr_burst) ? 2'b10 : 2'b00;
        axi.s_axi_rvalid  = (r_left > 0) && (axi.s_axi_rvalid === 1'b1 || !bp || $urandom_range(0, 1) == 1);
        axi.s_axi_rdata   = mem[r_idx % 8] ^ ((r_idx == corrupt_idx) ? 32'h1 : 32'h0);
        axi.s_axi_rlast   = (r_idx == prem_rlast) || (r_idx % BL == BL - 1);
        axi.s_axi_rresp   = 2'b00;
    end

    always @(negedge axi_aclk) begin
        axi2.s_axi_awready = 1'b1; axi2.s_axi_wready = 1'b1; axi2.s_axi_arready = 1'b1;
        axi2.s_axi_bvalid = 1'b1;  axi2.s_axi_bresp = 2'b00;
        axi2.s_axi_rvalid = 1'b0;  axi2.s_axi_rdata = '0; axi2.s_axi_rlast = 1'b0; axi2.s_axi_rresp = 2'b00;
    end

    always @(posedge axi_aclk) begin
        if (axi2.s_axi_awvalid && axi2.s_axi_awready) aw2_log.push_back(axi2.s_axi_awaddr);
        if (axi2.s_axi_wvalid && axi2.s_axi_wready) begin
            last_wd2 = axi2.s_axi_wdata;
            if (axi2.s_axi_wlast) wlast2_cnt++;
        end
        if (wr_done2) wr_done2_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        clr_seq++;
        @(negedge axi_aclk);
    endtask

    task automatic pulse_write();
        @(negedge axi_aclk); start_write = 1'b1;
        @(negedge axi_aclk); start_write = 1'b0;
    endtask

    task automatic pulse_read();
        @(negedge axi_aclk); start_read = 1'b1;
        @(negedge axi_aclk); start_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] ctl;
        ctl = {axi.s_axi_awvalid, axi.s_axi_wvalid, axi.s_axi_bready, axi.s_axi_arvalid, axi.s_axi_rready,
               axi.s_axi_wlast, wr_busy, rd_busy, wr_done, rd_done, 2'b00, axi.s_axi_wstrb};
        n_cmp++; if (ctl !== 16'h0) begin n_bad++; $display("FAIL reset_ctl: got %h expected 0000", ctl); end
        n_cmp++; if (axi.s_axi_awaddr !== 32'h0) begin n_bad++; $display("FAIL reset_awaddr: got %h expected 0", axi.s_axi_awaddr); end
        n_cmp++; if (axi.s_axi_araddr !== 32'h0) begin n_bad++; $display("FAIL reset_araddr: got %h expected 0", axi.s_axi_araddr); end
        n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err: got %h expected 0", err_cnt); end
    endtask

    task automatic test_write();
        int wd0 = wr_done_cnt, sv0 = strb_viol;
        clear_logs();
        pulse_write();
        n_cmp++; if ({wr_busy, axi.s_axi_awvalid} !== 2'b11) begin n_bad++; $display("FAIL wr_start: got busy/awvalid %b expected 11", {wr_busy, axi.s_axi_awvalid}); end
        n_cmp++; if ({axi.s_axi_awlen, axi.s_axi_awsize, axi.s_axi_awburst, axi.s_axi_awcache} !== {8'd3, 3'd2, 2'd1, 4'd3})
            begin n_bad++; $display("FAIL aw_consts: got len %0d size %0d burst %0d cache %0d expected 3 2 1 3", axi.s_axi_awlen, axi.s_axi_awsize, axi.s_axi_awburst, axi.s_axi_awcache); end
        pulse_write();  // must be ignored: frame in progress
        for (int k = 0; k < 2000 && wr_done_cnt == wd0; k++) @(negedge axi_aclk);
        repeat (4) @(negedge axi_aclk);
        n_cmp++; if (wr_done_cnt - wd0 != 1) begin n_bad++; $display("FAIL wr_done_pulses: got %0d expected 1", wr_done_cnt - wd0); end
        n_cmp++; if (wr_busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b expected 0", wr_busy); end
        n_cmp++; if (aw_log.size() != 2) begin n_bad++; $display("FAIL wr_aw_count: got %0d expected 2", aw_log.size()); end
        else begin
            n_cmp++; if (aw_log[0] !== 32'h0 || aw_log[1] !== 32'h10) begin n_bad++; $display("FAIL wr_awaddr: got %h %h expected 0 10", aw_log[0], aw_log[1]); end
        end
        n_cmp++; if (wd_log.size() != 8) begin n_bad++; $display("FAIL wr_beats: got %0d expected 8", wd_log.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++; if (wd_log[i] !== 32'(i) || wl_log[i] !== (i % 4 == 3))
                begin n_bad++; $display("FAIL wr_beat%0d: got data %h last %b expected %h %b", i, wd_log[i], wl_log[i], i, (i % 4 == 3)); end
        end
        n_cmp++; if (strb_viol != sv0) begin n_bad++; $display("FAIL wstrb: got %0d bad cycles expected 0", strb_viol - sv0); end
    endtask

    task automatic test_read();
        int rd0 = rd_done_cnt;
        clear_logs();
        pulse_read();
        n_cmp++; if ({rd_busy, axi.s_axi_arvalid} !== 2'b11) begin n_bad++; $display("FAIL rd_start: got busy/arvalid %b expected 11", {rd_busy, axi.s_axi_arvalid}); end
        n_cmp++; if ({axi.s_axi_arlen, axi.s_axi_arsize, axi.s_axi_arburst, axi.s_axi_arcache} !== {8'd3, 3'd2, 2'd1, 4'd3})
            begin n_bad++; $display("FAIL ar_consts: got len %0d size %0d expected 3 2", axi.s_axi_arlen, axi.s_axi_arsize); end
        for (int k = 0; k < 2000 && rd_done_cnt == rd0; k++) @(negedge axi_aclk);
        repeat (3) @(negedge axi_aclk);
        n_cmp++; if (rd_done_cnt - rd0 != 1) begin n_bad++; $display("FAIL rd_done_pulses: got %0d expected 1", rd_done_cnt - rd0); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL rd_clean_err: got %0d expected 0", err_cnt); end
        n_cmp++; if (ar_log.size() != 2 || ar_log[0] !== 32'h0 || ar_log[1] !== 32'h10)
            begin n_bad++; $display("FAIL rd_araddr: got %0d addrs expected 0,10", ar_log.size()); end
        corrupt_idx = 5;
        rd0 = rd_done_cnt;
        clear_logs();
        pulse_read();
        for (int k = 0; k < 2000 && rd_done_cnt == rd0; k++) @(negedge axi_aclk);
        corrupt_idx = -1;
        n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL rd_corrupt_err: got %0d expected 1", err_cnt); end
        n_cmp++; if (rd_busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end: got %b expected 0", rd_busy); end
    endtask

    task automatic test_backpressure();
        int wd0 = wr_done_cnt, rd0 = rd_done_cnt, st0 = stab_viol;
        bp = 1;
        clear_logs();
        pulse_write();
        for (int k = 0; k < 4000 && wr_done_cnt == wd0; k++) @(negedge axi_aclk);
        n_cmp++; if (wr_done_cnt == wd0) begin n_bad++; $display("FAIL bp_wr_timeout: got no wr_done expected 1"); end
        n_cmp++; if (wd_log.size() != 8) begin n_bad++; $display("FAIL bp_wr_beats: got %0d expected 8", wd_log.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_cmp++; if (wd_log[i] !== 32'(i)) begin n_bad++; $display("FAIL bp_beat%0d: got %h expected %h", i, wd_log[i], i); end
        end
        n_cmp++; if (aw_log.size() != 2 || aw_log[1] !== 32'h10) begin n_bad++; $display("FAIL bp_awaddr: got %0d addrs expected 2 ending 10", aw_log.size()); end
        pulse_read();
        for (int k = 0; k < 4000 && rd_done_cnt == rd0; k++) @(negedge axi_aclk);
        n_cmp++; if (rd_done_cnt == rd0) begin n_bad++; $display("FAIL bp_rd_timeout: got no rd_done expected 1"); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL bp_rd_err: got %0d expected 0", err_cnt); end
        n_cmp++; if (stab_viol != st0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stab_viol - st0); end
        bp = 0;
    endtask

    task automatic test_errors();
        int wd0 = wr_done_cnt, rd0 = rd_done_cnt;
        slverr_burst = 0; prem_rlast = 2;
        clear_logs();
        @(negedge axi_aclk); start_write = 1'b1; start_read = 1'b1;
        @(negedge axi_aclk); start_write = 1'b0; start_read = 1'b0;
        for (int k = 0; k < 3000 && (wr_done_cnt == wd0 || rd_done_cnt == rd0); k++) @(negedge axi_aclk);
        repeat (2) @(negedge axi_aclk);
        n_cmp++; if (err_cnt !== 16'd2) begin n_bad++; $display("FAIL slverr_rlast_err: got %0d expected 2", err_cnt); end
        n_cmp++; if ({wr_busy, rd_busy} !== 2'b00) begin n_bad++; $display("FAIL concurrent_busy: got %b expected 00", {wr_busy, rd_busy}); end
        slverr_burst = -1; prem_rlast = -1;
    endtask

    task automatic test_reset_mid();
        int wd0;
        clear_logs();
        pulse_write();
        for (int k = 0; k < 200 && wd_log.size() < 2; k++) @(negedge axi_aclk);
        n_cmp++; if (axi.s_axi_wvalid !== 1'b1) begin n_bad++; $display("FAIL mid_in_wdata: got wvalid %b expected 1", axi.s_axi_wvalid); end
        #2 axi_aresetn = 1'b0;
        #1;
        n_cmp++; if ({axi.s_axi_awvalid, axi.s_axi_wvalid, axi.s_axi_wlast, axi.s_axi_bready, wr_busy, wr_done, axi.s_axi_wstrb} !== 10'h0)
            begin n_bad++; $display("FAIL mid_reset_ctl: got wvalid %b busy %b expected 0", axi.s_axi_wvalid, wr_busy); end
        n_cmp++; if (axi.s_axi_awaddr !== 32'h0 || axi.s_axi_wdata !== 32'h0 || err_cnt !== 16'h0)
            begin n_bad++; $display("FAIL mid_reset_vals: got addr %h data %h err %0d expected 0", axi.s_axi_awaddr, axi.s_axi_wdata, err_cnt); end
        @(negedge axi_aclk); axi_aresetn = 1'b1;
        wd0 = wr_done_cnt;
        clear_logs();
        pulse_write();
        for (int k = 0; k < 2000 && wr_done_cnt == wd0; k++) @(negedge axi_aclk);
        n_cmp++; if (aw_log.size() != 2 || aw_log[0] !== 32'h0) begin n_bad++; $display("FAIL restart_addr: got %0d addrs expected first 0", aw_log.size()); end
        n_cmp++; if (wd_log.size() != 8 || wd_log[0] !== 32'h0 || wd_log[7] !== 32'h7)
            begin n_bad++; $display("FAIL restart_data: got %0d beats expected 8 from 0 to 7", wd_log.size()); end
    endtask

    task automatic test_wide();
        @(negedge axi_aclk); start_write2 = 1'b1;
        @(negedge axi_aclk); start_write2 = 1'b0;
        n_cmp++; if (axi2.s_axi_awlen !== 8'hFF || axi2.s_axi_awsize !== 3'd3)
            begin n_bad++; $display("FAIL wide_consts: got len %h size %0d expected ff 3", axi2.s_axi_awlen, axi2.s_axi_awsize); end
        for (int k = 0; k < 3000 && wr_done2_cnt == 0; k++) @(negedge axi_aclk);
        @(negedge axi_aclk);
        n_cmp++; if (wr_done2_cnt != 1) begin n_bad++; $display("FAIL wide_done: got %0d expected 1", wr_done2_cnt); end
        n_cmp++; if (aw2_log.size() != 2 || aw2_log[0] !== 32'h0 || aw2_log[1] !== 32'h800)
            begin n_bad++; $display("FAIL wide_step: got %0d addrs expected 0 and 800", aw2_log.size()); end
        n_cmp++; if (last_wd2 !== 64'd511 || wlast2_cnt != 2)
            begin n_bad++; $display("FAIL wide_data: got last %0d wlasts %0d expected 511 2", last_wd2, wlast2_cnt); end
    endtask

    initial begin
        repeat (3) @(negedge axi_aclk);
        test_reset();
        axi_aresetn = 1'b1;
        repeat (2) @(negedge axi_aclk);
        test_write();
        test_read();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
